// File: rtl/kitchen_pkg.sv
// kitchen_pkg: grid/player/direction codes, grid geometry and helpers
// shared by kitchen_grid_writer and the graphics block.
package kitchen_pkg;

  localparam int GW = 8;
  localparam int GH = 13;

  localparam logic signed [10:0] ORIGIN = 11'sd112;

  localparam logic [3:0] CHOP_COUNT   = 4'd3;
  localparam logic [3:0] COOK_TICKS   = 4'd5;
  localparam logic [3:0] BURN_TICKS   = 4'd8;
  localparam logic [3:0] SPREAD_TICKS = 4'd4;

  localparam logic [3:0] G_EMPTY         = 4'd0;
  localparam logic [3:0] G_ONION_WHOLE   = 4'd1;
  localparam logic [3:0] G_ONION_CHOPPED = 4'd2;
  localparam logic [3:0] G_BOWL_EMPTY    = 4'd3;
  localparam logic [3:0] G_BOWL_FULL     = 4'd4;
  localparam logic [3:0] G_POT_EMPTY     = 4'd5;
  localparam logic [3:0] G_POT_RAW       = 4'd6;
  localparam logic [3:0] G_POT_COOKED    = 4'd7;
  localparam logic [3:0] G_POT_FIRE      = 4'd8;
  localparam logic [3:0] G_FIRE          = 4'd9;
  localparam logic [3:0] G_EXTINGUISHER  = 4'd10;

  localparam logic [3:0] P_NOTHING       = 4'd0;
  localparam logic [3:0] P_ONION_WHOLE   = 4'd1;
  localparam logic [3:0] P_ONION_CHOPPED = 4'd2;
  localparam logic [3:0] P_BOWL_EMPTY    = 4'd3;
  localparam logic [3:0] P_BOWL_FULL     = 4'd4;
  localparam logic [3:0] P_POT_EMPTY     = 4'd5;
  localparam logic [3:0] P_EXT_OFF       = 4'd6;
  localparam logic [3:0] P_EXT_ON        = 4'd7;

  localparam logic [1:0] P_LEFT  = 2'd0;
  localparam logic [1:0] P_RIGHT = 2'd1;
  localparam logic [1:0] P_UP    = 2'd2;
  localparam logic [1:0] P_DOWN  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RESOLVE,
    S_APPLY,
    S_SWEEP
  } state_e;

  typedef logic [GW-1:0][GH-1:0][3:0] grid_t;

  typedef struct packed {
    logic [2:0] x;
    logic [3:0] y;
    logic       inb;
    logic [3:0] obj;
    logic [3:0] tim;
  } cell_t;

  function automatic grid_t init_grid();
    grid_t g;
    g = '0;
    g[0][0] = G_ONION_WHOLE;
    g[1][0] = G_POT_EMPTY;
    g[2][0] = G_BOWL_EMPTY;
    g[3][0] = G_EXTINGUISHER;
    return g;
  endfunction

  localparam grid_t INIT_GRID = init_grid();

  // P_NOTHING means the cell cannot be picked up.
  function automatic logic [3:0] pickup_map(input logic [3:0] g);
    case (g)
      G_ONION_WHOLE:   return P_ONION_WHOLE;
      G_ONION_CHOPPED: return P_ONION_CHOPPED;
      G_BOWL_EMPTY:    return P_BOWL_EMPTY;
      G_BOWL_FULL:     return P_BOWL_FULL;
      G_POT_EMPTY:     return P_POT_EMPTY;
      G_EXTINGUISHER:  return P_EXT_OFF;
      default:         return P_NOTHING;
    endcase
  endfunction

  function automatic logic [3:0] place_map(input logic [3:0] p);
    case (p)
      P_ONION_WHOLE:   return G_ONION_WHOLE;
      P_ONION_CHOPPED: return G_ONION_CHOPPED;
      P_BOWL_EMPTY:    return G_BOWL_EMPTY;
      P_BOWL_FULL:     return G_BOWL_FULL;
      P_POT_EMPTY:     return G_POT_EMPTY;
      P_EXT_OFF:       return G_EXTINGUISHER;
      P_EXT_ON:        return G_EXTINGUISHER;
      default:         return G_EMPTY;
    endcase
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hf) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/kitchen_grid_writer_target.sv
// grid_target_calc: sprite pixel position + facing -> faced grid cell,
// with an in-bounds flag.
module grid_target_calc
  import kitchen_pkg::*;
(
  input  logic [8:0] px_i,
  input  logic [8:0] py_i,
  input  logic [1:0] dir_i,
  output logic [2:0] tx_o,
  output logic [3:0] ty_o,
  output logic       inb_o
);

  logic signed [10:0] cx, cy, fx, fy;

  always_comb begin
    // sprite centre, floored to a 32 px cell
    cx = ($signed({2'b00, px_i}) + 11'sd16 - ORIGIN) >>> 5;
    cy = ($signed({2'b00, py_i}) + 11'sd16 - ORIGIN) >>> 5;
    fx = cx;
    fy = cy;
    unique case (dir_i)
      P_LEFT:  fx = cx - 11'sd1;
      P_RIGHT: fx = cx + 11'sd1;
      P_UP:    fy = cy - 11'sd1;
      P_DOWN:  fy = cy + 11'sd1;
    endcase
    inb_o = (fx >= 11'sd0) && (fx < $signed(11'(GW)))
         && (fy >= 11'sd0) && (fy < $signed(11'(GH)));
    tx_o = fx[2:0];
    ty_o = fy[3:0];
  end

endmodule

// File: rtl/kitchen_grid_writer.sv
// kitchen_grid_writer: owns object/time grids and held item; resolves
// grab/use and sweeps timers per tick. FIRE_SPREAD_EN enables fire spread.
module kitchen_grid_writer
  import kitchen_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [8:0] player_x,
  input  logic [8:0] player_y,
  input  logic [1:0] player_direction,
  input  logic       grab,
  input  logic       use_i,
  input  logic       tick,
  output grid_t      object_grid,
  output grid_t      time_grid,
  output logic [3:0] player_state,
  output logic       busy,
  output logic       update_done
);

  state_e     st_q;
  grid_t      obj_q, tim_q;
  logic [3:0] ply_q;
  cell_t      tgt_q;
  logic       grab_q, done_q;
  logic       act_pend_q, pend_grab_q, tick_pend_q;
  logic [2:0] sx_q;
  logic [3:0] sy_q;

  logic [2:0] tx;
  logic [3:0] ty;
  logic       inb;
  logic       act_in;

  grid_target_calc u_tgt (
    .px_i  (player_x),
    .py_i  (player_y),
    .dir_i (player_direction),
    .tx_o  (tx),
    .ty_o  (ty),
    .inb_o (inb)
  );

  assign act_in = grab | use_i;

  logic [3:0] ap_obj_d, ap_tim_d, ap_ply_d, ap_inc;
  logic       holding, is_ext;

  always_comb begin
    ap_obj_d = tgt_q.obj;
    ap_tim_d = tgt_q.tim;
    ap_ply_d = ply_q;
    ap_inc   = sat_inc(tgt_q.tim);
    holding  = (ply_q != P_NOTHING);
    is_ext   = (ply_q == P_EXT_OFF) || (ply_q == P_EXT_ON);
    if (grab_q) begin
      unique case (1'b1)
        !holding: begin
          if (pickup_map(tgt_q.obj) != P_NOTHING) begin
            ap_ply_d = pickup_map(tgt_q.obj);
            ap_obj_d = G_EMPTY;
            ap_tim_d = '0;
          end
        end
        holding && tgt_q.obj == G_EMPTY: begin
          ap_obj_d = place_map(ply_q);
          ap_tim_d = '0;
          ap_ply_d = P_NOTHING;
        end
        ply_q == P_ONION_CHOPPED && tgt_q.obj == G_POT_EMPTY: begin
          ap_obj_d = G_POT_RAW;
          ap_tim_d = '0;
          ap_ply_d = P_NOTHING;
        end
        ply_q == P_BOWL_EMPTY && tgt_q.obj == G_POT_COOKED: begin
          ap_obj_d = G_POT_EMPTY;
          ap_tim_d = '0;
          ap_ply_d = P_BOWL_FULL;
        end
        default: ;
      endcase
    end else begin
      unique case (1'b1)
        !holding && tgt_q.obj == G_ONION_WHOLE: begin
          if (ap_inc == CHOP_COUNT) begin
            ap_obj_d = G_ONION_CHOPPED;
            ap_tim_d = '0;
          end else begin
            ap_tim_d = ap_inc;
          end
        end
        is_ext && tgt_q.obj == G_POT_FIRE: begin
          ap_obj_d = G_POT_EMPTY;
          ap_tim_d = '0;
        end
        is_ext && tgt_q.obj == G_FIRE: begin
          ap_obj_d = G_EMPTY;
          ap_tim_d = '0;
        end
        default: ;
      endcase
    end
  end

  logic [3:0] cur_obj, cur_tim, sw_obj_d, sw_tim_d, sw_inc;
  logic [2:0] nx;
  logic       spread_d;

  always_comb begin
    cur_obj  = obj_q[sx_q][sy_q];
    cur_tim  = tim_q[sx_q][sy_q];
    sw_obj_d = cur_obj;
    sw_tim_d = cur_tim;
    sw_inc   = sat_inc(cur_tim);
    nx       = sx_q + 3'd1;
    spread_d = 1'b0;
    case (cur_obj)
      G_POT_RAW: begin
        if (sw_inc == COOK_TICKS) begin
          sw_obj_d = G_POT_COOKED;
          sw_tim_d = '0;
        end else begin
          sw_tim_d = sw_inc;
        end
      end
      G_POT_COOKED: begin
        if (sw_inc == BURN_TICKS) begin
          sw_obj_d = G_POT_FIRE;
          sw_tim_d = '0;
        end else begin
          sw_tim_d = sw_inc;
        end
      end
`ifdef FIRE_SPREAD_EN
      G_POT_FIRE: begin
        if (sw_inc == SPREAD_TICKS) begin
          sw_tim_d = '0;
          spread_d = (sx_q != 3'(GW - 1))
                  && (obj_q[nx][sy_q] == G_EMPTY);
        end else begin
          sw_tim_d = sw_inc;
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st_q        <= S_IDLE;
      obj_q       <= INIT_GRID;
      tim_q       <= '0;
      ply_q       <= P_NOTHING;
      tgt_q       <= '0;
      grab_q      <= 1'b0;
      done_q      <= 1'b0;
      act_pend_q  <= 1'b0;
      pend_grab_q <= 1'b0;
      tick_pend_q <= 1'b0;
      sx_q        <= '0;
      sy_q        <= '0;
    end else begin
      done_q <= 1'b0;
      // a tick during a sweep is absorbed by that sweep
      if (st_q != S_IDLE) begin
        if (act_in && !act_pend_q) begin
          act_pend_q  <= 1'b1;
          pend_grab_q <= grab;
        end
        if (tick && st_q != S_SWEEP) tick_pend_q <= 1'b1;
      end
      unique case (st_q)
        S_IDLE: begin
          if (act_pend_q || act_in) begin
            st_q        <= S_RESOLVE;
            grab_q      <= act_pend_q ? pend_grab_q : grab;
            act_pend_q  <= act_pend_q & act_in;
            pend_grab_q <= grab;
            if (tick) tick_pend_q <= 1'b1;
          end else if (tick_pend_q || tick) begin
            st_q        <= S_SWEEP;
            tick_pend_q <= 1'b0;
            sx_q        <= '0;
            sy_q        <= '0;
          end
        end
        S_RESOLVE: begin
          tgt_q <= '{x:   tx,
                     y:   ty,
                     inb: inb,
                     obj: inb ? obj_q[tx][ty] : G_EMPTY,
                     tim: inb ? tim_q[tx][ty] : 4'd0};
          st_q  <= S_APPLY;
        end
        S_APPLY: begin
          if (tgt_q.inb) begin
            obj_q[tgt_q.x][tgt_q.y] <= ap_obj_d;
            tim_q[tgt_q.x][tgt_q.y] <= ap_tim_d;
            ply_q                   <= ap_ply_d;
          end
          done_q <= 1'b1;
          st_q   <= S_IDLE;
        end
        S_SWEEP: begin
          obj_q[sx_q][sy_q] <= sw_obj_d;
          tim_q[sx_q][sy_q] <= sw_tim_d;
          if (spread_d) obj_q[nx][sy_q] <= G_FIRE;
          if (sy_q == 4'(GH - 1)) begin
            sy_q <= '0;
            if (sx_q == 3'(GW - 1)) st_q <= S_IDLE;
            else sx_q <= sx_q + 3'd1;
          end else begin
            sy_q <= sy_q + 4'd1;
          end
        end
      endcase
    end
  end

  assign object_grid  = obj_q;
  assign time_grid    = tim_q;
  assign player_state = ply_q;
  assign busy         = (st_q != S_IDLE);
  assign update_done  = done_q;

endmodule
